// File: rtl/jk_latch_bank_arbiter.sv
// Two-requester arbiter and enable sequencer for a bank of gated JK latches.
// Define JK_PRIORITY_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module jk_latch_bank_arbiter #(
    parameter int WIDTH         = 4,
    parameter int ENABLE_CYCLES = 1
) (
    input  logic             i_cp,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_j0,
    input  logic [WIDTH-1:0] i_k0,
    output logic             o_gnt0,
    output logic             o_done0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_j1,
    input  logic [WIDTH-1:0] i_k1,
    output logic             o_gnt1,
    output logic             o_done1,
    output logic             o_enable,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ENABLE_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             owner;
    logic             win;
    logic [WIDTH-1:0] cmd_j;
    logic [WIDTH-1:0] cmd_k;
    logic [WIDTH-1:0] res_j;
    logic [WIDTH-1:0] res_k;

`ifndef JK_PRIORITY_EN
    logic last;
`endif

    // Toggle (J=K=1) becomes an explicit set or reset against the Q snapshot,
    // so the bank never sees J=K=1 while enabled.
    always_comb begin
`ifdef JK_PRIORITY_EN
        win = ~i_req0;
`else
        if (i_req0 && i_req1) win = ~last;
        else                  win = ~i_req0;
`endif
        cmd_j = win ? i_j1 : i_j0;
        cmd_k = win ? i_k1 : i_k0;
        res_j = (cmd_j & ~cmd_k) | (cmd_j & cmd_k & ~i_q);
        res_k = (cmd_k & ~cmd_j) | (cmd_j & cmd_k & i_q);
    end

    always_ff @(posedge i_cp) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            o_gnt0   <= 1'b0;
            o_gnt1   <= 1'b0;
            o_done0  <= 1'b0;
            o_done1  <= 1'b0;
            o_enable <= 1'b0;
            o_j      <= '0;
            o_k      <= '0;
            o_rdata  <= '0;
            o_busy   <= 1'b0;
`ifndef JK_PRIORITY_EN
            last     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        owner  <= win;
                        o_gnt0 <= ~win;
                        o_gnt1 <= win;
                        o_j    <= res_j;
                        o_k    <= res_k;
                        o_busy <= 1'b1;
                        state  <= SETUP;
`ifndef JK_PRIORITY_EN
                        last   <= win;
`endif
                    end
                end
                SETUP: begin
                    o_gnt0   <= 1'b0;
                    o_gnt1   <= 1'b0;
                    o_enable <= 1'b1;
                    cnt      <= CNT_LAST;
                    state    <= PULSE;
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        o_enable <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    o_rdata <= i_q;
                    o_done0 <= ~owner;
                    o_done1 <= owner;
                    o_j     <= '0;
                    o_k     <= '0;
                    state   <= DONE;
                end
                DONE: begin
                    o_done0 <= 1'b0;
                    o_done1 <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_latch_bank_arbiter.sv
// Scoreboard bench for jk_latch_bank_arbiter with a behavioural latch bank.
// Grants are queued as expected when requests are driven; checked at grant/done.
module tb_jk_latch_bank_arbiter;

    localparam int W = 4;
    localparam int E = 2;

    logic         clk;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] j0, k0, j1, k1;
    logic         gnt0, gnt1, done0, done1;
    logic         enable;
    logic [W-1:0] oj, ok, rdata;
    logic         busy;
    logic [W-1:0] bank_q;
    logic         load_en;
    logic [W-1:0] load_val;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit           who;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } exp_t;

    exp_t exp_q[$];

    jk_latch_bank_arbiter #(.WIDTH(W), .ENABLE_CYCLES(E)) dut (
        .i_cp    (clk),
        .i_rst   (rst),
        .i_req0  (req0),
        .i_j0    (j0),
        .i_k0    (k0),
        .o_gnt0  (gnt0),
        .o_done0 (done0),
        .i_req1  (req1),
        .i_j1    (j1),
        .i_k1    (k1),
        .o_gnt1  (gnt1),
        .o_done1 (done1),
        .o_enable(enable),
        .o_j     (oj),
        .o_k     (ok),
        .i_q     (bank_q),
        .o_rdata (rdata),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch bank: updates only while enabled, J/K never both high here.
    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else if (enable) bank_q <= (bank_q & ~ok) | oj;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void resolve(input logic [W-1:0] j, input logic [W-1:0] k,
                                    input logic [W-1:0] q,
                                    output logic [W-1:0] rj,
                                    output logic [W-1:0] rk);
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   begin rj[i] = 1'b0;  rk[i] = 1'b0; end
                2'b01:   begin rj[i] = 1'b0;  rk[i] = 1'b1; end
                2'b10:   begin rj[i] = 1'b1;  rk[i] = 1'b0; end
                default: begin rj[i] = ~q[i]; rk[i] = q[i]; end
            endcase
        end
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    bit           active = 0;
    int           age, en_cnt;
    exp_t         cur;
    logic [W-1:0] ej, ek, er;

    always @(negedge clk) begin
        chk("jk_excl", 32'(oj & ok), 0);
        if (rst) begin
            chk("rst_out", {gnt0, gnt1, done0, done1, enable, busy, oj, ok, rdata}, 0);
            active = 0;
        end else if (gnt0 | gnt1) begin
            if (exp_q.size() == 0) begin
                chk("unexp_gnt", {gnt1, gnt0}, 0);
            end else begin
                cur = exp_q.pop_front();
                chk("gnt_who", {gnt1, gnt0}, cur.who ? 2'b10 : 2'b01);
                resolve(cur.j, cur.k, bank_q, ej, ek);
                er = (bank_q & ~ek) | ej;
                chk("setup_j", oj, ej);
                chk("setup_k", ok, ek);
                chk("setup_en", enable, 0);
                chk("setup_busy", busy, 1);
                active = 1;
                age    = 0;
                en_cnt = 0;
            end
        end else if (active) begin
            age++;
            if (enable) en_cnt++;
            if (age <= E + 1) begin
                chk("hold_j", oj, ej);
                chk("hold_k", ok, ek);
                chk("enable", enable, (age <= E) ? 1 : 0);
                chk("early_done", {done1, done0}, 0);
            end else begin
                chk("done_who", {done1, done0}, cur.who ? 2'b10 : 2'b01);
                chk("rdata", rdata, er);
                chk("en_cycles", en_cnt, E);
                chk("done_jk", {oj, ok}, 0);
                active = 0;
            end
        end else begin
            chk("idle_done", {done1, done0}, 0);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit who, input logic [W-1:0] j, input logic [W-1:0] k);
        exp_t e;
        e.who = who;
        e.j   = j;
        e.k   = k;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic wait_gnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt0 | gnt1) return;
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done0 | done1) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic op(input bit who, input logic [W-1:0] j, input logic [W-1:0] k);
        push(who, j, k);
        if (who) begin j1 = j; k1 = k; req1 = 1'b1; end
        else     begin j0 = j; k0 = k; req0 = 1'b1; end
        wait_gnt();
        req0 = 1'b0;
        req1 = 1'b0;
        j0 = W'($urandom);
        k0 = W'($urandom);
        j1 = W'($urandom);
        k1 = W'($urandom);
        wait_done();
    endtask

    int dones, g0, d0;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        j0 = '0; k0 = '0; j1 = '0; k1 = '0;
        load_en = 1'b0;
        load_val = '0;
        bank_q = '0;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out", {gnt0, gnt1, done0, done1, enable, busy, oj, ok, rdata}, 0);
        end

        load(4'b0000);
        op(1'b0, 4'b1010, 4'b0000);
        load(4'b0110);
        op(1'b1, 4'b1111, 4'b1111);

        // Contention with both requests held.
        load(4'b0000);
`ifdef JK_PRIORITY_EN
        for (int i = 0; i < 4; i++) push(1'b0, 4'b0001, 4'b0001);
`else
        for (int i = 0; i < 4; i++)
            push(i[0], i[0] ? 4'b1000 : 4'b0001, i[0] ? 4'b1000 : 4'b0001);
`endif
        j0 = 4'b0001; k0 = 4'b0001;
        j1 = 4'b1000; k1 = 4'b1000;
        req0 = 1'b1;
        req1 = 1'b1;
        dones = 0;
        for (int i = 0; i < 80 && dones < 4; i++) begin
            tick();
            if (done0 | done1) dones++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("cont_dones", dones, 4);
        repeat (3) tick();

        // Reset in PULSE, after requester 0 was granted last.
        op(1'b0, 4'b0100, 4'b0000);
        push(1'b0, 4'b0010, 4'b0000);
        j0 = 4'b0010; k0 = 4'b0000;
        req0 = 1'b1;
        wait_gnt();
        req0 = 1'b0;
        tick();
        chk("pulse_en", enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        push(1'b0, 4'b0001, 4'b0000);
        j0 = 4'b0001; k0 = 4'b0000;
        j1 = 4'b1000; k1 = 4'b0000;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt();
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done();

        // Requester 0 pulses only while requester 1 is in SETUP.
        push(1'b1, 4'b0011, 4'b0000);
        j1 = 4'b0011; k1 = 4'b0000;
        req1 = 1'b1;
        wait_gnt();
        req1 = 1'b0;
        req0 = 1'b1;
        g0 = 0;
        d0 = 0;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            g0 += int'(gnt0);
            d0 += int'(done0);
            tick();
        end
        chk("no_gnt0", g0, 0);
        chk("no_done0", d0, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
